// File: rtl/mazegen_pkg.sv
// mazegen_pkg: shared state enum, seed constants and LFSR step for the maze generator controller
package mazegen_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RESET, S_WAIT, S_STREAM} state_t;
    localparam logic [15:0] SEED_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/mazegen_ctrl_row_streamer.sv
// row_streamer: holds the captured maze and walks it out one row per valid/ready handshake
module row_streamer #(
    parameter int size = 16,
    parameter int N    = $clog2(size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [size*size-1:0] maze,
    input  logic                 active,
    input  logic                 row_ready,
    output logic                 row_valid,
    output logic [size-1:0]      row_data,
    output logic [N-1:0]         row_idx,
    output logic                 row_last,
    output logic                 last_acc
);
    localparam logic [N-1:0] LAST = N'(size - 1);
    logic [size*size-1:0] snap;
    // snapshot on capture, then advance the row pointer on every accepted row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap    <= '0;
            row_idx <= '0;
        end else if (capture) begin
            snap    <= maze;
            row_idx <= '0;
        end else if (active && row_ready) begin
            row_idx <= (row_idx == LAST) ? '0 : row_idx + 1'b1;
        end
    end
    assign row_valid = active;
    assign row_data  = snap[row_idx*size +: size];
    assign row_last  = active && row_idx == LAST;
    assign last_acc  = active && row_ready && row_idx == LAST;
endmodule

// File: rtl/mazegen_ctrl.sv
// mazegen_ctrl: sequences seed load, generator reset, watchdogged wait and row streaming
module mazegen_ctrl import mazegen_pkg::*; #(
    parameter int          size       = 16,
    parameter int          N          = $clog2(size),
    parameter int          RST_CYCLES = 2,
    parameter int          TIMEOUT    = 20000,
    parameter logic [15:0] SEED_INIT  = mazegen_pkg::SEED_INIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 seed_load,
    input  logic [15:0]          seed_in,
    output logic                 gen_rst,
    output logic [15:0]          gen_seed,
    input  logic                 gen_done,
    input  logic [size*size-1:0] gen_maze,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [size-1:0]      row_data,
    output logic [N-1:0]         row_idx,
    output logic                 row_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_t        state, nxt;
    logic [15:0]   seed_q;
    logic [RW-1:0] rcnt;
    logic [WW-1:0] wcnt;
    logic          capture, accept, tmo, last_acc;
    // next-state selection; abort overrides every other transition
    always_comb begin
        nxt     = state;
        capture = 1'b0;
        case (state)
            S_IDLE:   if (start && !seed_load) nxt = S_RESET;
            S_RESET:  if (rcnt == RW'(RST_CYCLES - 1)) nxt = S_WAIT;
            S_WAIT:   if (gen_done) begin
                          nxt     = S_STREAM;
                          capture = 1'b1;
                      end else if (wcnt == WW'(TIMEOUT - 1)) nxt = S_IDLE;
            S_STREAM: if (last_acc) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            nxt     = S_IDLE;
            capture = 1'b0;
        end
    end
    assign accept  = state == S_IDLE && start && !seed_load;
    assign tmo     = state == S_WAIT && !gen_done && !abort && wcnt == WW'(TIMEOUT - 1);
    assign gen_rst = state != S_WAIT;
    assign busy    = state != S_IDLE;
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end
    // seed LFSR, generator seed, phase counters and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q      <= SEED_INIT;
            gen_seed    <= SEED_INIT;
            timeout_err <= 1'b0;
            frame_done  <= 1'b0;
            rcnt        <= '0;
            wcnt        <= '0;
        end else begin
            if (state == S_IDLE && seed_load) seed_q <= (seed_in == 16'h0) ? SEED_INIT : seed_in;
            else if (accept)                  seed_q <= lfsr16_next(seed_q);
            if (accept) gen_seed <= seed_q;
            timeout_err <= accept ? 1'b0 : (tmo ? 1'b1 : timeout_err);
            frame_done  <= state == S_STREAM && last_acc && !abort;
            rcnt        <= state == S_RESET ? rcnt + 1'b1 : '0;
            wcnt        <= state == S_WAIT ? wcnt + 1'b1 : '0;
        end
    end
    row_streamer #(.size(size), .N(N)) u_rows (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .maze      (gen_maze),
        .active    (state == S_STREAM),
        .row_ready (row_ready),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .last_acc  (last_acc)
    );
endmodule

// File: tb/tb_mazegen_ctrl.sv
// tb_mazegen_ctrl: table-driven, hand-sequenced and random checks of the maze generator controller
module tb_mazegen_ctrl;
    localparam int SZ = 4;
    logic          clk = 1'b0, rst = 1'b0;
    logic          start = 1'b0, abort = 1'b0, seed_load = 1'b0, row_ready = 1'b0;
    logic [15:0]   seed_in = '0;
    logic          gen_rst, gen_done = 1'b0, row_valid, row_last, busy, frame_done, timeout_err;
    logic [15:0]   gen_seed;
    logic [SZ*SZ-1:0] gen_maze = '0;
    logic [SZ-1:0] row_data;
    logic [1:0]    row_idx;
    int            total = 0, bad = 0;
    int            scnt = 0;
    bit            stub_en = 1'b1;
    logic [15:0]   m_seed = 16'hACE1;

    mazegen_ctrl #(.size(SZ), .RST_CYCLES(2), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_load(seed_load),
        .seed_in(seed_in), .gen_rst(gen_rst), .gen_seed(gen_seed), .gen_done(gen_done),
        .gen_maze(gen_maze), .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .row_idx(row_idx), .row_last(row_last), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // generator stub: raises done five cycles after its reset is released
    always @(negedge clk) begin
        if (gen_rst) begin
            scnt = 0;
            gen_done = 1'b0;
        end else begin
            scnt++;
            gen_done = stub_en && scnt >= 5;
        end
    end

    function automatic logic [15:0] step(input logic [15:0] s);
        logic [15:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        seed_load = 1'b1;
        seed_in = v;
        @(negedge clk);
        seed_load = 1'b0;
        chk("load_not_busy", busy, 0);
        m_seed = (v == 0) ? 16'hACE1 : v;
    endtask

    task automatic do_start(input logic [15:0] exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_gen_rst", gen_rst, 1);
        chk("start_seed", gen_seed, exp);
        chk("start_clears_tmo", timeout_err, 0);
        m_seed = step(m_seed);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (row_valid) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("wait_valid_bound", 0, 1);
    endtask

    task automatic do_frame(input logic [15:0] maze, input int mode, input logic [15:0] exp);
        bit ok;
        int ei, cyc;
        logic rdy;
        logic [3:0] pat;
        pat = 4'b1001;
        gen_maze = maze;
        stub_en = 1'b1;
        do_start(exp);
        @(negedge clk);
        chk("gen_rst_hold", gen_rst, 1);
        @(negedge clk);
        chk("gen_rst_release", gen_rst, 0);
        wait_valid(ok);
        gen_maze = ~maze;
        ei = 0;
        cyc = 0;
        while (ok && ei < SZ && cyc < 200) begin
            chk("row_valid", row_valid, 1);
            chk("row_idx", row_idx, ei);
            chk("row_data", row_data, (maze >> (SZ * ei)) & 16'hF);
            chk("row_last", row_last, ei == SZ - 1);
            chk("no_early_done", frame_done, 0);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            row_ready = rdy;
            @(negedge clk);
            if (rdy) ei++;
            cyc++;
        end
        row_ready = 1'b0;
        if (ok) begin
            chk("frame_rows", ei, SZ);
            chk("frame_done", frame_done, 1);
            chk("frame_idle", busy, 0);
            chk("frame_valid_off", row_valid, 0);
            @(negedge clk);
            chk("frame_done_once", frame_done, 0);
        end
    endtask

    typedef struct {
        bit          ld;
        logic [15:0] sin;
        logic [15:0] maze;
        int          mode;
        logic [15:0] exp_seed;
    } vec_t;
    vec_t tbl[4];

    initial begin
        bit ok;
        int n;
        logic [15:0] s;
        tbl[0] = '{1'b0, 16'h0000, 16'h8421, 0, 16'hACE1};
        tbl[1] = '{1'b0, 16'h0000, 16'hA5C3, 1, 16'hE270};
        tbl[2] = '{1'b1, 16'h0000, 16'h3C96, 1, 16'hACE1};
        tbl[3] = '{1'b1, 16'h1234, 16'hF00F, 0, 16'h1234};
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gen_rst", gen_rst, 1);
        chk("rst_gen_seed", gen_seed, 16'hACE1);
        chk("rst_valid", row_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_row_data", row_data, 0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].ld) do_load(tbl[i].sin);
            do_frame(tbl[i].maze, tbl[i].mode, tbl[i].exp_seed);
        end
        start = 1'b1;
        seed_load = 1'b1;
        seed_in = 16'h00F0;
        @(negedge clk);
        start = 1'b0;
        seed_load = 1'b0;
        chk("load_beats_start", busy, 0);
        m_seed = 16'h00F0;
        stub_en = 1'b0;
        do_start(16'h00F0);
        n = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            if (!gen_rst) n++;
            @(negedge clk);
        end
        chk("timeout_wait_cycles", n, 50);
        chk("timeout_idle", busy, 0);
        chk("timeout_err_set", timeout_err, 1);
        start = 1'b1;
        @(negedge clk);
        chk("busy_start_ignored", busy, 1);
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_tmo2", timeout_err, 0);
        m_seed = step(m_seed);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wait_idle", busy, 0);
        s = m_seed;
        gen_maze = 16'h1357;
        stub_en = 1'b1;
        do_start(s);
        wait_valid(ok);
        row_ready = 1'b1;
        for (int i = 0; i < 10 && row_idx != 2; i++) @(negedge clk);
        chk("abort_at_row2", row_idx, 2);
        row_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_valid", row_valid, 0);
        chk("abort_no_done", frame_done, 0);
        chk("abort_seed_kept", gen_seed, s);
        @(negedge clk);
        chk("abort_no_done2", frame_done, 0);
        do_start(m_seed);
        for (int i = 0; i < 10 && gen_rst; i++) @(negedge clk);
        chk("in_wait", gen_rst, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_idle", busy, 0);
        chk("arst_gen_rst", gen_rst, 1);
        chk("arst_seed", gen_seed, 16'hACE1);
        chk("arst_valid", row_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        m_seed = 16'hACE1;
        @(negedge clk);
        chk("arst_no_done", frame_done, 0);
        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 3);
            if (n == 0) do_load(16'h0);
            else if (n == 1) do_load(16'($urandom));
            do_frame(16'($urandom), 2, m_seed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
